// File: rtl/rif_arb_pkg.sv
// Shared types and helpers for the register-interface arbiter.
// Imported by rif_arbiter and rr_arbiter.
package rif_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } rif_arb_state_t;

    // Width of a requester index; a single requester still needs one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
// The pointer itself is owned by the caller.
module rr_arbiter
    import rif_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    localparam int unsigned IDX_W  = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx
);

    logic              found;
    int unsigned       pos;
    logic [IDX_W-1:0]  cand;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        pos     = 0;
        cand    = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            pos = 32'(ptr) + off;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            cand = IDX_W'(pos);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/rif_arbiter.sv
// Round-robin arbiter sharing one rif target between NUM_REQ requesters.
// One access at a time: accept, single-cycle rif strobe, registered response.
module rif_arbiter
    import rif_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BYTE_COUNT = DATA_WIDTH / 8
) (
    input  logic                           HCLK,
    input  logic                           HRESETn,

    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0]             req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*BYTE_COUNT-1:0]  req_wstrb,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,

    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DATA_WIDTH-1:0]          rsp_rdata,
    output logic                           rsp_err,

    output logic [ADDR_WIDTH-1:0]          rif_addr,
    input  logic                           rif_addr_valid,
    output logic                           rif_wr_req,
    output logic                           rif_rd_req,
    output logic [BYTE_COUNT-1:0]          rif_wstrb,
    output logic [DATA_WIDTH-1:0]          rif_wdata,
    input  logic [DATA_WIDTH-1:0]          rif_rdata
);

    localparam int unsigned IDX_W = idx_width(NUM_REQ);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  write;
        logic [BYTE_COUNT-1:0] wstrb;
        logic [DATA_WIDTH-1:0] wdata;
    } cmd_t;

    rif_arb_state_t         state_q;
    logic [IDX_W-1:0]       ptr_q;
    logic [IDX_W-1:0]       gnt_idx_q;
    cmd_t                   cmd_q;
    logic                   rif_wr_req_q;
    logic                   rif_rd_req_q;
    logic [NUM_REQ-1:0]     rsp_valid_q;
    logic [DATA_WIDTH-1:0]  rsp_rdata_q;
    logic                   rsp_err_q;

    logic [NUM_REQ-1:0]     gnt;
    logic [IDX_W-1:0]       gnt_idx;
    logic [IDX_W-1:0]       ptr_nxt;
    logic [NUM_REQ-1:0]     gnt_oh_q;
    cmd_t                   req_cmd [NUM_REQ];
    cmd_t                   sel_cmd;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req     (req_valid),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_cmd
        assign req_cmd[i] = '{
            addr:  req_addr[i*ADDR_WIDTH +: ADDR_WIDTH],
            write: req_write[i],
            wstrb: req_wstrb[i*BYTE_COUNT +: BYTE_COUNT],
            wdata: req_wdata[i*DATA_WIDTH +: DATA_WIDTH]
        };
    end

    assign sel_cmd = req_cmd[gnt_idx];
    assign ptr_nxt = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);

    always_comb begin
        gnt_oh_q = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            gnt_oh_q[i] = (gnt_idx_q == IDX_W'(i));
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            gnt_idx_q    <= '0;
            cmd_q        <= '0;
            rif_wr_req_q <= 1'b0;
            rif_rd_req_q <= 1'b0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (|gnt) begin
                        cmd_q        <= sel_cmd;
                        gnt_idx_q    <= gnt_idx;
                        ptr_q        <= ptr_nxt;
                        rif_wr_req_q <= sel_cmd.write;
                        rif_rd_req_q <= ~sel_cmd.write;
                        state_q      <= ISSUE;
                    end
                end
                ISSUE: begin
                    rif_wr_req_q <= 1'b0;
                    rif_rd_req_q <= 1'b0;
                    rsp_err_q    <= ~rif_addr_valid;
                    // Writes and decode misses return zero data.
                    rsp_rdata_q  <= (!cmd_q.write && rif_addr_valid) ? rif_rdata : '0;
                    rsp_valid_q  <= gnt_oh_q;
                    state_q      <= RESP;
                end
                RESP: begin
                    rsp_valid_q <= '0;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Gate with HRESETn so the combinational grant is also zero during reset.
    assign req_ready  = (state_q == IDLE && HRESETn) ? gnt : '0;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_err    = rsp_err_q;
    assign rif_addr   = cmd_q.addr;
    assign rif_wr_req = rif_wr_req_q;
    assign rif_rd_req = rif_rd_req_q;
    assign rif_wstrb  = rif_wr_req_q ? cmd_q.wstrb : '0;
    assign rif_wdata  = rif_wr_req_q ? cmd_q.wdata : '0;

endmodule

// File: tb/tb_rif_arbiter.sv
// Directed bench for rif_arbiter: per-cycle vector table on a 2-port instance,
// plus sequences for back-to-back rotation, reset in ISSUE and a 3-port instance.
module tb_rif_arbiter;

    logic HCLK;
    logic HRESETn;

    // Two-requester instance
    logic [1:0]  rv, rw, rdy, rspv;
    logic [11:0] a0, a1;
    logic [31:0] wd0, wd1;
    logic [3:0]  ws0, ws1;
    logic [31:0] rsp_rdata, rif_wdata, rif_rdata;
    logic        rsp_err, rif_addr_valid, rif_wr_req, rif_rd_req;
    logic [11:0] rif_addr;
    logic [3:0]  rif_wstrb;

    // Three-requester instance
    logic [2:0]  rv3, rdy3, rspv3;
    logic [31:0] rsp_rdata3, rif_wdata3;
    logic        rsp_err3, rif_wr_req3, rif_rd_req3;
    logic [11:0] rif_addr3;
    logic [3:0]  rif_wstrb3;

    int checks = 0;
    int errors = 0;

    rif_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(12), .DATA_WIDTH(32)) dut (
        .HCLK           (HCLK),
        .HRESETn        (HRESETn),
        .req_valid      (rv),
        .req_ready      (rdy),
        .req_write      (rw),
        .req_addr       ({a1, a0}),
        .req_wstrb      ({ws1, ws0}),
        .req_wdata      ({wd1, wd0}),
        .rsp_valid      (rspv),
        .rsp_rdata      (rsp_rdata),
        .rsp_err        (rsp_err),
        .rif_addr       (rif_addr),
        .rif_addr_valid (rif_addr_valid),
        .rif_wr_req     (rif_wr_req),
        .rif_rd_req     (rif_rd_req),
        .rif_wstrb      (rif_wstrb),
        .rif_wdata      (rif_wdata),
        .rif_rdata      (rif_rdata)
    );

    rif_arbiter #(.NUM_REQ(3), .ADDR_WIDTH(12), .DATA_WIDTH(32)) dut3 (
        .HCLK           (HCLK),
        .HRESETn        (HRESETn),
        .req_valid      (rv3),
        .req_ready      (rdy3),
        .req_write      (3'b000),
        .req_addr       ({12'h300, 12'h200, 12'h100}),
        .req_wstrb      (12'h0),
        .req_wdata      (96'h0),
        .rsp_valid      (rspv3),
        .rsp_rdata      (rsp_rdata3),
        .rsp_err        (rsp_err3),
        .rif_addr       (rif_addr3),
        .rif_addr_valid (1'b1),
        .rif_wr_req     (rif_wr_req3),
        .rif_rd_req     (rif_rd_req3),
        .rif_wstrb      (rif_wstrb3),
        .rif_wdata      (rif_wdata3),
        .rif_rdata      (32'h0000_3333)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [1:0]  rv, rw;
        logic [11:0] a0, a1;
        logic [31:0] wd0;
        logic [3:0]  ws0;
        logic        av;
        logic [31:0] rd;
        logic [1:0]  e_rdy;
        logic        e_wr, e_rd;
        logic [11:0] e_addr;
        logic [3:0]  e_ws;
        logic [31:0] e_wd;
        logic [1:0]  e_rspv;
        logic        e_err;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        int n;
        int cyc_at [4];
        int who [4];

        //         rv     rw     a0      a1      wd0           ws0   av    rd
        //         rdy    wr    rd    addr    ws    wd            rspv   err   rdata
        vecs[0]  = '{2'b00, 2'b00, 12'h000, 12'h020, 32'h0,        4'h0, 1'b1, 32'h0,
                     2'b00, 1'b0, 1'b0, 12'h000, 4'h0, 32'h0,        2'b00, 1'b0, 32'h0};
        vecs[1]  = '{2'b01, 2'b01, 12'h010, 12'h020, 32'hDEADBEEF, 4'hF, 1'b1, 32'h0,
                     2'b01, 1'b0, 1'b0, 12'h000, 4'h0, 32'h0,        2'b00, 1'b0, 32'h0};
        vecs[2]  = '{2'b00, 2'b01, 12'h010, 12'h020, 32'hDEADBEEF, 4'hF, 1'b1, 32'hAAAAAAAA,
                     2'b00, 1'b1, 1'b0, 12'h010, 4'hF, 32'hDEADBEEF, 2'b00, 1'b0, 32'h0};
        vecs[3]  = '{2'b00, 2'b00, 12'h010, 12'h020, 32'h0,        4'h0, 1'b1, 32'h0,
                     2'b00, 1'b0, 1'b0, 12'h010, 4'h0, 32'h0,        2'b01, 1'b0, 32'h0};
        vecs[4]  = '{2'b10, 2'b00, 12'h010, 12'h020, 32'h0,        4'h0, 1'b1, 32'h0,
                     2'b10, 1'b0, 1'b0, 12'h010, 4'h0, 32'h0,        2'b00, 1'b0, 32'h0};
        vecs[5]  = '{2'b00, 2'b00, 12'h010, 12'h020, 32'h0,        4'h0, 1'b1, 32'h12345678,
                     2'b00, 1'b0, 1'b1, 12'h020, 4'h0, 32'h0,        2'b00, 1'b0, 32'h0};
        vecs[6]  = '{2'b00, 2'b00, 12'h010, 12'h020, 32'h0,        4'h0, 1'b1, 32'h0,
                     2'b00, 1'b0, 1'b0, 12'h020, 4'h0, 32'h0,        2'b10, 1'b0, 32'h12345678};
        vecs[7]  = '{2'b01, 2'b00, 12'h7FF, 12'h020, 32'hCAFEF00D, 4'hF, 1'b1, 32'h0,
                     2'b01, 1'b0, 1'b0, 12'h020, 4'h0, 32'h0,        2'b00, 1'b0, 32'h0};
        vecs[8]  = '{2'b00, 2'b00, 12'h7FF, 12'h020, 32'hCAFEF00D, 4'hF, 1'b0, 32'hFFFFFFFF,
                     2'b00, 1'b0, 1'b1, 12'h7FF, 4'h0, 32'h0,        2'b00, 1'b0, 32'h0};
        vecs[9]  = '{2'b01, 2'b01, 12'h030, 12'h020, 32'h0BADF00D, 4'h3, 1'b1, 32'h0,
                     2'b00, 1'b0, 1'b0, 12'h7FF, 4'h0, 32'h0,        2'b01, 1'b1, 32'h0};
        vecs[10] = '{2'b01, 2'b01, 12'h030, 12'h020, 32'h0BADF00D, 4'h3, 1'b1, 32'h0,
                     2'b01, 1'b0, 1'b0, 12'h7FF, 4'h0, 32'h0,        2'b00, 1'b0, 32'h0};
        vecs[11] = '{2'b00, 2'b00, 12'h030, 12'h020, 32'h0BADF00D, 4'h3, 1'b1, 32'h0,
                     2'b00, 1'b1, 1'b0, 12'h030, 4'h3, 32'h0BADF00D, 2'b00, 1'b0, 32'h0};
        vecs[12] = '{2'b00, 2'b00, 12'h030, 12'h020, 32'h0,        4'h0, 1'b1, 32'h0,
                     2'b00, 1'b0, 1'b0, 12'h030, 4'h0, 32'h0,        2'b01, 1'b0, 32'h0};
        vecs[13] = '{2'b00, 2'b00, 12'h030, 12'h020, 32'h0,        4'h0, 1'b1, 32'h0,
                     2'b00, 1'b0, 1'b0, 12'h030, 4'h0, 32'h0,        2'b00, 1'b0, 32'h0};
        vecs[14] = '{2'b11, 2'b00, 12'h030, 12'h020, 32'h0,        4'h0, 1'b1, 32'h0,
                     2'b10, 1'b0, 1'b0, 12'h030, 4'h0, 32'h0,        2'b00, 1'b0, 32'h0};
        vecs[15] = '{2'b00, 2'b00, 12'h030, 12'h020, 32'h0,        4'h0, 1'b1, 32'h55AA55AA,
                     2'b00, 1'b0, 1'b1, 12'h020, 4'h0, 32'h0,        2'b00, 1'b0, 32'h0};
        vecs[16] = '{2'b00, 2'b00, 12'h030, 12'h020, 32'h0,        4'h0, 1'b1, 32'h0,
                     2'b00, 1'b0, 1'b0, 12'h020, 4'h0, 32'h0,        2'b10, 1'b0, 32'h55AA55AA};

        HRESETn = 1'b0;
        rv = '0; rw = '0; a0 = '0; a1 = 12'h020;
        wd0 = '0; ws0 = '0; wd1 = 32'h11111111; ws1 = 4'hF;
        rif_addr_valid = 1'b1; rif_rdata = '0;
        rv3 = '0;

        // Reset state
        @(negedge HCLK);
        chk("reset_rdy", rdy, 0);
        chk("reset_rspv", rspv, 0);
        chk("reset_strobes", {rif_wr_req, rif_rd_req}, 0);
        chk("reset_rif_addr", rif_addr, 0);
        chk("reset_rsp", {rsp_err, rsp_rdata}, 0);
        next_cycle();
        HRESETn = 1'b1;

        for (int i = 0; i < 17; i++) begin
            rv = vecs[i].rv; rw = vecs[i].rw; a0 = vecs[i].a0; a1 = vecs[i].a1;
            wd0 = vecs[i].wd0; ws0 = vecs[i].ws0;
            rif_addr_valid = vecs[i].av; rif_rdata = vecs[i].rd;
            @(negedge HCLK);
            chk($sformatf("v%0d_ready", i), rdy, vecs[i].e_rdy);
            chk($sformatf("v%0d_wr_req", i), rif_wr_req, vecs[i].e_wr);
            chk($sformatf("v%0d_rd_req", i), rif_rd_req, vecs[i].e_rd);
            chk($sformatf("v%0d_rif_addr", i), rif_addr, vecs[i].e_addr);
            chk($sformatf("v%0d_rif_wstrb", i), rif_wstrb, vecs[i].e_ws);
            chk($sformatf("v%0d_rif_wdata", i), rif_wdata, vecs[i].e_wd);
            chk($sformatf("v%0d_rsp_valid", i), rspv, vecs[i].e_rspv);
            if (vecs[i].e_rspv != 2'b00) begin
                chk($sformatf("v%0d_rsp_err", i), rsp_err, vecs[i].e_err);
                chk($sformatf("v%0d_rsp_rdata", i), rsp_rdata, vecs[i].e_rdata);
            end
            next_cycle();
        end

        // Both requesters held valid from reset: 0,1,0,1 accepted 3 cycles apart
        HRESETn = 1'b0;
        rv = 2'b11; rw = 2'b00; rif_addr_valid = 1'b1; rif_rdata = 32'h0;
        @(negedge HCLK);
        chk("rr_reset_rdy", rdy, 0);
        next_cycle();
        HRESETn = 1'b1;
        n = 0;
        for (int k = 0; k < 4; k++) begin
            cyc_at[k] = -1;
            who[k] = -1;
        end
        for (int c = 0; c < 20 && n < 4; c++) begin
            @(negedge HCLK);
            if (rdy != 2'b00) begin
                cyc_at[n] = c;
                who[n] = rdy[1] ? 1 : 0;
                n++;
            end
            next_cycle();
        end
        chk("rr_grant_count", n, 4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rr_who%0d", k), who[k], k % 2);
            chk($sformatf("rr_cycle%0d", k), cyc_at[k], 3 * k);
        end

        // Reset asserted during ISSUE
        rv = 2'b00;
        HRESETn = 1'b0;
        next_cycle();
        HRESETn = 1'b1;
        rv = 2'b01; rw = 2'b00; a0 = 12'h044;
        @(negedge HCLK);
        chk("rst_accept", rdy, 2'b01);
        next_cycle();
        rv = 2'b00;
        @(negedge HCLK);
        chk("rst_issue_rd", rif_rd_req, 1);
        HRESETn = 1'b0;
        #1;
        chk("rst_strobes_drop", {rif_wr_req, rif_rd_req}, 0);
        chk("rst_rif_addr", rif_addr, 0);
        chk("rst_rspv", rspv, 0);
        next_cycle();
        HRESETn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge HCLK);
            chk($sformatf("rst_no_rsp%0d", c), rspv, 0);
            next_cycle();
        end
        rv = 2'b11;
        @(negedge HCLK);
        chk("rst_first_grant", rdy, 2'b01);
        next_cycle();
        rv = 2'b00;

        // Three requesters: move the pointer to 2, then all valid -> 2,0,1
        rv3 = 3'b010;
        @(negedge HCLK);
        chk("n3_first", rdy3, 3'b010);
        next_cycle();
        rv3 = 3'b000;
        @(negedge HCLK);
        chk("n3_issue", rif_rd_req3, 1);
        chk("n3_issue_addr", rif_addr3, 12'h200);
        next_cycle();
        @(negedge HCLK);
        chk("n3_rsp", rspv3, 3'b010);
        chk("n3_rdata", rsp_rdata3, 32'h0000_3333);
        next_cycle();
        rv3 = 3'b111;
        n = 0;
        for (int k = 0; k < 4; k++) who[k] = -1;
        for (int c = 0; c < 12 && n < 3; c++) begin
            @(negedge HCLK);
            if (rdy3 != 3'b000) begin
                who[n] = rdy3[2] ? 2 : (rdy3[1] ? 1 : 0);
                n++;
            end
            next_cycle();
        end
        rv3 = 3'b000;
        chk("n3_grant_count", n, 3);
        chk("n3_order0", who[0], 2);
        chk("n3_order1", who[1], 0);
        chk("n3_order2", who[2], 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
